// File: rtl/z80_io_resp.sv
// z80_io_resp: Z80 I/O-mapped peripheral with an output latch, a prescaled
// down-counting timer that raises a maskable interrupt, an interrupt vector
// register served during the acknowledge cycle, and optional wait states.
//
// Register map (index = addr[1:0], block decoded where addr[7:2] == BASE[7:2]):
//   0 PORT_OUT  RW  drives port_out
//   1 CTRL      RW  bit0 TE, bit1 IE; write bit7=1 clears PEND; read {PEND,5'b0,IE,TE}
//   2 RELOAD    RW  write also loads the counter and restarts the prescaler
//   3 VECTOR    RW  placed on dout during the interrupt acknowledge cycle
//
// Optional build macro: IO_RESP_WAIT_EN
//   defined   -> wait_n is pulled low for WAIT_CYCLES clocks at each I/O cycle start
//   undefined -> wait_n is tied high and the wait counter is not built

module z80_io_resp #(
    parameter logic [7:0] BASE        = 8'h10,
    parameter int         PRESCALE    = 256,
    parameter int         WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        m1_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    output logic        wait_n,
    output logic        int_n,
    output logic [7:0]  port_out
);

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    // Registers
    logic [7:0]    r_port_out;
    logic          r_te;
    logic          r_ie;
    logic          r_pend;
    logic [7:0]    r_reload;
    logic [7:0]    r_vector;
    logic [7:0]    r_cnt;
    logic [PW-1:0] r_presc;
    logic          r_io_prev;
    logic          r_ack_prev;
    logic          r_wr_done;

    // Decode and cycle qualification
    logic       w_hit;
    logic       w_io_cyc;
    logic       w_ack_cyc;
    logic       w_ack_start;
    logic       w_wr_commit;
    logic       w_wr_ctrl;
    logic       w_wr_reload;
    logic       w_tick;
    logic       w_pend_set;
    logic       w_pend_clr;
    logic [1:0] w_idx;
    logic [7:0] w_ctrl_rd;
    logic       w_addr_hi_unused;

    assign w_addr_hi_unused = ^addr[15:8];

    assign w_idx       = addr[1:0];
    assign w_hit       = (addr[7:2] == BASE[7:2]);
    assign w_io_cyc    = ~iorq_n & m1_n & w_hit;
    assign w_ack_cyc   = ~iorq_n & ~m1_n;
    assign w_ack_start = w_ack_cyc & ~r_ack_prev;

    // A write lands on the first clock of the cycle that sees wr_n low; r_wr_done
    // blocks any further commit until the cycle condition drops.
    assign w_wr_commit = w_io_cyc & ~wr_n & ~r_wr_done;
    assign w_wr_ctrl   = w_wr_commit & (w_idx == 2'd1);
    assign w_wr_reload = w_wr_commit & (w_idx == 2'd2);

    assign w_tick      = r_te & (r_presc == PRE_MAX);
    // A RELOAD write in the same clock as a tick restarts the count and swallows that tick.
    assign w_pend_set  = w_tick & ~w_wr_reload & (r_cnt == 8'd0);
    assign w_pend_clr  = w_ack_start | (w_wr_ctrl & din[7]);

    assign w_ctrl_rd   = {r_pend, 5'b0_0000, r_ie, r_te};

    assign port_out    = r_port_out;
    assign int_n       = ~(r_pend & r_ie);

    // Cycle-edge tracking; reset primes the "previous" flags so a cycle already in
    // progress at reset release is not taken as a fresh start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_io_prev  <= 1'b1;
            r_ack_prev <= 1'b1;
            r_wr_done  <= 1'b1;
        end else begin
            r_io_prev  <= w_io_cyc;
            r_ack_prev <= w_ack_cyc;
            if (!w_io_cyc) begin
                r_wr_done <= 1'b0;
            end else if (!wr_n) begin
                r_wr_done <= 1'b1;
            end
        end
    end

    // CPU-visible register writes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_port_out <= 8'h00;
            r_te       <= 1'b0;
            r_ie       <= 1'b0;
            r_reload   <= 8'h00;
            r_vector   <= 8'hFF;
        end else if (w_wr_commit) begin
            case (w_idx)
                2'd0: r_port_out <= din;
                2'd1: begin
                    r_te <= din[0];
                    r_ie <= din[1];
                end
                2'd2: r_reload <= din;
                default: r_vector <= din;
            endcase
        end
    end

    // Prescaler and timer counter; counter reloads from RELOAD when it expires at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_cnt   <= 8'h00;
        end else if (w_wr_reload) begin
            r_presc <= '0;
            r_cnt   <= din;
        end else if (!r_te) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_cnt   <= (r_cnt == 8'd0) ? r_reload : (r_cnt - 8'd1);
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Interrupt pending flag; a same-clock expiry beats any clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 1'b0;
        end else if (w_pend_set) begin
            r_pend <= 1'b1;
        end else if (w_pend_clr) begin
            r_pend <= 1'b0;
        end
    end

    // Read data mux toward the CPU data bus
    always_comb begin
        dout = 8'hFF;
        if (w_io_cyc && !rd_n) begin
            case (w_idx)
                2'd0:    dout = r_port_out;
                2'd1:    dout = w_ctrl_rd;
                2'd2:    dout = r_reload;
                default: dout = r_vector;
            endcase
        end else if (w_ack_cyc) begin
            dout = r_vector;
        end
    end

`ifdef IO_RESP_WAIT_EN
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    logic       w_io_start;
    logic [3:0] r_wait_cnt;

    assign w_io_start = w_io_cyc & ~r_io_prev;
    assign wait_n     = (r_wait_cnt == 4'd0);

    // Wait-state down-counter armed at each I/O cycle start, dropped when the cycle ends
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
        end else if (w_io_start) begin
            r_wait_cnt <= WAIT_LD;
        end else if (!w_io_cyc) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end
`else
    assign wait_n = 1'b1;
`endif

endmodule

// File: doc/z80_io_resp.md
Z80_IO_RESP -- requirements
Module: z80_io_resp

Interface
REQ-001 Parameter BASE, 8'h10, I/O base port; block decodes ports where addr[7:2]==BASE[7:2], register index = addr[1:0].
REQ-002 Parameter PRESCALE, 256, clk cycles per timer tick (>=1).
REQ-003 Parameter WAIT_CYCLES, 2, wait states inserted per I/O access (1..15).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 addr  in  16  CPU address bus; only addr[7:0] decoded.
REQ-007 din  in  8  CPU write data (CPU dout).
REQ-008 dout  out  8  read data to CPU di.
REQ-009 m1_n, iorq_n, rd_n, wr_n  in  1 each  Z80 bus strobes, active-low.
REQ-010 wait_n  out  1  wait request to CPU, active-low.
REQ-011 int_n  out  1  maskable interrupt request, active-low.
REQ-012 port_out  out  8  general-purpose output latch.

Function
REQ-013 I/O cycle = iorq_n=0 & m1_n=1 & addr decode hit; ack cycle = iorq_n=0 & m1_n=0 (no decode).
REQ-014 Cycle start = first clk where cycle condition true and it was false the previous clk; cycle ends when iorq_n returns to 1.
REQ-015 Registers: 0 PORT_OUT (RW, drives port_out); 1 CTRL (bit0 TE timer enable, bit1 IE interrupt enable, write bit7=1 clears PEND); 2 RELOAD (RW); 3 VECTOR (RW).
REQ-016 CTRL read value = {PEND, 5'b0, IE, TE}.
REQ-017 Write commits exactly once per I/O cycle, on first clk with wr_n=0 inside the cycle; held wr_n shall not re-commit.
REQ-018 dout combinational: selected register during I/O read (rd_n=0), VECTOR during ack cycle, 8'hFF otherwise.
REQ-019 Prescaler counts 0..PRESCALE-1, tick on wrap; runs only while TE=1, cleared to 0 when TE=0.
REQ-020 Timer counter CNT (8 bit): on tick, CNT==0 -> CNT<=RELOAD and PEND<=1; else CNT<=CNT-1.
REQ-021 Write to RELOAD also loads CNT with written value and clears prescaler; RELOAD=0 sets PEND every tick.
REQ-022 int_n = ~(PEND & IE), registered-state-derived, no combinational path from bus inputs.
REQ-023 Ack cycle start clears PEND.
REQ-024 Simultaneous set and clear of PEND (tick expiry vs. ack start or CTRL bit7 write): set wins, PEND=1.
REQ-025 Non-decoded I/O cycles and memory cycles: no register change, wait_n=1.

Reset
REQ-026 On reset: PORT_OUT=00, TE=IE=PEND=0, RELOAD=00, CNT=00, prescaler=0, VECTOR=FF, wait state counter idle.
REQ-027 Outputs after reset: port_out=00, int_n=1, wait_n=1, dout=FF (no cycle active).
REQ-028 Reset mid-cycle aborts wait sequence; wait_n=1 next clk; in-progress cycle is not treated as new start after reset release unless iorq_n first returns high.

Configuration
REQ-029 Macro IO_RESP_WAIT_EN defined: at each I/O cycle start wait_n=0 for exactly WAIT_CYCLES clks, then 1 until cycle end; ack cycles get no wait states.
REQ-030 IO_RESP_WAIT_EN undefined: wait_n tied to 1, wait counter logic absent, all other behaviour identical.

Verification
REQ-031 Reset, then OUT (0x10),0xA5 -> port_out=A5 one clk after wr_n low; IN (0x10) returns A5; port 0x14 read -> FF, port_out unchanged.
REQ-032 PRESCALE=4, RELOAD=3, CTRL=03 -> PEND and int_n=0 after 16 clks (4 ticks); CTRL read = 83.
REQ-033 VECTOR=0x40, pending interrupt, ack cycle (m1_n=0,iorq_n=0) -> dout=40, int_n=1 next clk.
REQ-034 Tick expiry on same clk as ack start -> PEND remains 1, int_n stays 0.
REQ-035 With IO_RESP_WAIT_EN, WAIT_CYCLES=2, IN (0x11) -> wait_n low exactly 2 clks from cycle start; without macro wait_n never 0.
REQ-036 Assert reset during wait-state sequence with TE=1 -> next clk wait_n=1, int_n=1, port_out=00, CTRL read 00.
